// File: rtl/pipe_wb_port_arbiter.sv
// Write-back port arbiter.
// Merges pipeline WB writes and queued multi-cycle MDU results onto one
// register-file write port. The pipeline always has priority. MDU results
// wait in a small FIFO and drain in idle WB slots. A two-state FSM requests
// front-end stalls when the FIFO fills or its head entry starves.
module pipe_wb_port_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTRW       = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            wwreg,
  input  logic            wm2reg,
  input  logic [31:0]     wmo,
  input  logic [31:0]     walu,
  input  logic [4:0]      wrn,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rn,
  input  logic [31:0]     mdu_res,
  output logic            mdu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_wn,
  output logic [31:0]     rf_d,
  output logic            stall_req,
  input  logic [4:0]      q_rs,
  input  logic [4:0]      q_rt,
  output logic            pend_rs,
  output logic            pend_rt,
  output logic [PTRW:0]   fifo_cnt
);

  localparam int unsigned AGEW = $clog2(STARVE_MAX + 1);
  localparam logic [PTRW:0]   CNT_FULL = (PTRW + 1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_HALF = (PTRW + 1)'(DEPTH / 2);
  localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(STARVE_MAX);
  localparam logic [AGEW:0]   AGE_LIM  = (AGEW + 1)'(STARVE_MAX);

  typedef enum logic {NORM, URGENT} state_t;

  logic [4:0]      rn_q   [DEPTH];
  logic [4:0]      rn_d   [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW:0]   cnt_q, cnt_d;
  logic [AGEW-1:0] age_q, age_d;
  state_t          state_q, state_d;

  logic pipe_wr;
  logic pop;
  logic store;
  logic starve;
  logic hit_rs, hit_rt;

  assign pipe_wr   = wwreg & (wrn != '0);
  assign pop       = ~pipe_wr & (cnt_q != '0);
  assign mdu_ready = (cnt_q < CNT_FULL);
  // r0 results are handshaken so the MDU retires them, but never occupy a slot.
  assign store     = mdu_valid & mdu_ready & (mdu_rn != '0);
  assign starve    = (({1'b0, age_q} + 1'b1) >= AGE_LIM);
  assign stall_req = (state_q == URGENT);
  assign fifo_cnt  = cnt_q;

  // Write-port mux: pipeline first, then FIFO head, else idle.
  always_comb begin
    rf_we = 1'b0;
    rf_wn = '0;
    rf_d  = '0;
    if (pipe_wr) begin
      rf_we = 1'b1;
      rf_wn = wrn;
      rf_d  = wm2reg ? wmo : walu;
    end else if (cnt_q != '0) begin
      rf_we = 1'b1;
      rf_wn = rn_q[rptr_q];
      rf_d  = data_q[rptr_q];
    end
  end

  // FIFO storage, pointers, occupancy and head-age next state.
  always_comb begin
    rn_d   = rn_q;
    data_d = data_q;
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    if (store) begin
      vld_d[wptr_q]  = 1'b1;
      rn_d[wptr_q]   = mdu_rn;
      data_d[wptr_q] = mdu_res;
      wptr_d         = wptr_q + 1'b1;
    end
    case ({store, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if ((cnt_q == '0) || pop)
      age_d = '0;
    else if (age_q == AGE_MAX)
      age_d = age_q;
    else
      age_d = age_q + 1'b1;
  end

  // Stall-request FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORM:    if (!pop && (starve || (cnt_d == CNT_FULL))) state_d = URGENT;
      URGENT:  if (pop && (cnt_d <= CNT_HALF))              state_d = NORM;
      default: state_d = NORM;
    endcase
  end

  // Pending-write lookup over live entries; an entry popping now still counts.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rn_q[i] == q_rs)) hit_rs = 1'b1;
      if (vld_q[i] && (rn_q[i] == q_rt)) hit_rt = 1'b1;
    end
    pend_rs = hit_rs & (q_rs != '0);
    pend_rt = hit_rt & (q_rt != '0);
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rn_q[i]   <= '0;
        data_q[i] <= '0;
      end
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      age_q   <= '0;
      state_q <= NORM;
    end else begin
      rn_q    <= rn_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
      state_q <= state_d;
    end
  end

endmodule
